// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding
// and the request legality check.
package lsu_defs;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_LOAD     = 2'b01,
        ST_RMW_READ = 2'b10,
        ST_WRITE    = 2'b11
    } lsu_state_e;

    // Unsigned loads have no store counterpart, so funct3 4/5 are illegal for stores.
    function automatic logic lsu_req_err(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int unsigned addr_bits
    );
        logic bad_f3;
        logic misaligned;
        logic out_of_range;
        bad_f3       = 1'b0;
        misaligned   = 1'b0;
        out_of_range = ((addr >> addr_bits) != 32'd0);
        case (funct3)
            F3_B:  misaligned = 1'b0;
            F3_H:  misaligned = addr[0];
            F3_W:  misaligned = (addr[1:0] != 2'b00);
            F3_BU: bad_f3 = we;
            F3_HU: begin
                bad_f3     = we;
                misaligned = addr[0];
            end
            default: bad_f3 = 1'b1;
        endcase
        return bad_f3 | misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge,
// both little-endian within the 32-bit memory word.
module lsu_align
    import lsu_defs::*;
(
    input  logic [31:0] mem_r_data,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [4:0]  byte_sh_s;
    logic [4:0]  half_sh_s;
    logic [31:0] byte_word_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] lane_mask_s;

    assign byte_sh_s   = {addr_lo, 3'b000};
    assign half_sh_s   = {addr_lo[1], 4'b0000};
    assign byte_word_s = mem_r_data >> byte_sh_s;
    assign byte_s      = byte_word_s[7:0];
    assign half_s      = addr_lo[1] ? mem_r_data[31:16] : mem_r_data[15:0];

    // Load data extraction with sign or zero extension
    always_comb begin
        rdata = 32'd0;
        case (funct3)
            F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
            F3_H:    rdata = {{16{half_s[15]}}, half_s};
            F3_W:    rdata = mem_r_data;
            F3_BU:   rdata = {24'd0, byte_s};
            F3_HU:   rdata = {16'd0, half_s};
            default: rdata = 32'd0;
        endcase
    end

    // Store merge: replace the addressed lane of the word just read
    always_comb begin
        lane_mask_s = 32'hFFFF_FFFF;
        merged      = wdata;
        case (funct3)
            F3_B: begin
                lane_mask_s = 32'h0000_00FF << byte_sh_s;
                merged      = (mem_r_data & ~lane_mask_s) | ({24'd0, wdata[7:0]} << byte_sh_s);
            end
            F3_H: begin
                lane_mask_s = 32'h0000_FFFF << half_sh_s;
                merged      = (mem_r_data & ~lane_mask_s) | ({16'd0, wdata[15:0]} << half_sh_s);
            end
            default: begin
                lane_mask_s = 32'hFFFF_FFFF;
                merged      = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one request at a time, word-granular memory accesses,
// read-modify-write for byte/half stores. Memory strobes decode from state only.
module load_store_unit
    import lsu_defs::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_r_enb,
    output logic        mem_w_enb,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data
);

    lsu_state_e  state_r;
    lsu_state_e  state_nxt_s;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] merge_r;
    logic [2:0]  funct3_r;
    logic        we_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [31:0] resp_rdata_r;
    logic        accept_s;
    logic        err_s;
    logic [31:0] align_rdata_s;
    logic [31:0] align_merged_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);
    assign err_s    = lsu_req_err(req_we, req_funct3, req_addr, ADDR_BITS);

    lsu_align u_align (
        .mem_r_data (mem_r_data),
        .wdata      (wdata_r),
        .addr_lo    (addr_r[1:0]),
        .funct3     (funct3_r),
        .rdata      (align_rdata_s),
        .merged     (align_merged_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; erroneous requests never leave IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !err_s) begin
                    if (!req_we) begin
                        state_nxt_s = ST_LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_RMW_READ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:     state_nxt_s = ST_IDLE;
            ST_RMW_READ: state_nxt_s = ST_WRITE;
            ST_WRITE:    state_nxt_s = ST_IDLE;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Moore decode of handshake and memory strobes
    always_comb begin
        req_ready  = 1'b0;
        mem_r_enb  = 1'b0;
        mem_w_enb  = 1'b0;
        mem_addr   = 32'd0;
        mem_w_data = 32'd0;
        case (state_r)
            ST_IDLE: req_ready = 1'b1;
            ST_LOAD, ST_RMW_READ: begin
                mem_r_enb = 1'b1;
                mem_addr  = {addr_r[31:2], 2'b00};
            end
            ST_WRITE: begin
                mem_w_enb  = 1'b1;
                mem_addr   = {addr_r[31:2], 2'b00};
                mem_w_data = merge_r;
            end
            default: req_ready = 1'b0;
        endcase
    end

    // Request latch, merge buffer and registered response
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            merge_r      <= 32'd0;
            funct3_r     <= 3'd0;
            we_r         <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        addr_r       <= req_addr;
                        wdata_r      <= req_wdata;
                        funct3_r     <= req_funct3;
                        we_r         <= req_we;
                        merge_r      <= req_wdata;
                        resp_valid_r <= err_s;
                        resp_err_r   <= err_s;
                    end
                end
                ST_LOAD: begin
                    resp_valid_r <= 1'b1;
                    resp_rdata_r <= we_r ? 32'd0 : align_rdata_s;
                end
                ST_RMW_READ: merge_r <= align_merged_s;
                ST_WRITE:    resp_valid_r <= 1'b1;
                default:     resp_valid_r <= 1'b0;
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory plus a byte-level
// reference model; directed plan items followed by random requests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_r_enb;
    logic        mem_w_enb;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    logic [7:0] dmem    [0:1023] = '{default: 8'h00};
    logic [7:0] ref_mem [0:1023] = '{default: 8'h00};

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_BITS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_r_enb  (mem_r_enb),
        .mem_w_enb  (mem_w_enb),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    always_comb begin
        mem_r_data = {dmem[{mem_addr[9:2], 2'b11}], dmem[{mem_addr[9:2], 2'b10}],
                      dmem[{mem_addr[9:2], 2'b01}], dmem[{mem_addr[9:2], 2'b00}]};
    end

    always @(posedge clk) begin
        if (mem_w_enb) begin
            dmem[{mem_addr[9:2], 2'b00}] <= mem_w_data[7:0];
            dmem[{mem_addr[9:2], 2'b01}] <= mem_w_data[15:8];
            dmem[{mem_addr[9:2], 2'b10}] <= mem_w_data[23:16];
            dmem[{mem_addr[9:2], 2'b11}] <= mem_w_data[31:24];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit ref_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = ref_size(f3);
        if (sz == 0) return 1'b1;
        if (we && f3 > 3'd2) return 1'b1;
        if (addr >= 32'd1024) return 1'b1;
        if ((addr % 32'(sz)) != 32'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a - (a % 4);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] dut_word(input int a);
        int b;
        b = a - (a % 4);
        return {dmem[b+3], dmem[b+2], dmem[b+1], dmem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int a;
        logic [31:0] v;
        a = int'(addr[9:0]);
        case (ref_size(f3))
            1: begin
                v = {24'd0, ref_mem[a]};
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            2: begin
                v = {16'd0, ref_mem[a+1], ref_mem[a]};
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = ref_word(a);
        endcase
        return v;
    endfunction

    // One complete request: predict, drive, observe response and strobes, compare.
    task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bit e;
        int sz, exp_lat, exp_wcyc, exp_rcnt, lat, rcnt, wcnt, wcyc, both, a;
        logic [31:0] exp_rdata, wdat, waddr, rdata_o;
        logic err_o;
        bit done;
        e  = ref_err(we, f3, addr);
        sz = ref_size(f3);
        a  = int'(addr[9:0]);
        exp_rdata = (!e && !we) ? ref_load(f3, addr) : 32'd0;
        if (e) begin
            exp_lat = 1; exp_wcyc = 0; exp_rcnt = 0;
        end else if (!we) begin
            exp_lat = 2; exp_wcyc = 0; exp_rcnt = 1;
        end else if (sz == 4) begin
            exp_lat = 2; exp_wcyc = 1; exp_rcnt = 0;
        end else begin
            exp_lat = 3; exp_wcyc = 2; exp_rcnt = 1;
        end
        if (!e && we) begin
            for (int i = 0; i < sz; i++) ref_mem[a + i] = wdata[8*i +: 8];
        end
        lat = 0; rcnt = 0; wcnt = 0; wcyc = 0; both = 0;
        wdat = 32'd0; waddr = 32'd0; rdata_o = 32'd0; err_o = 1'b0; done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        for (int n = 1; n <= 8 && !done; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (mem_r_enb) rcnt++;
            if (mem_w_enb) begin
                wcnt++; wcyc = n; wdat = mem_w_data; waddr = mem_addr;
            end
            if (mem_r_enb && mem_w_enb) both++;
            if (resp_valid) begin
                lat = n; rdata_o = resp_rdata; err_o = resp_err; done = 1'b1;
            end
        end
        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":err"}, {31'd0, err_o}, {31'd0, e});
        check({tag, ":rdata"}, rdata_o, exp_rdata);
        check({tag, ":rd_strobes"}, rcnt, exp_rcnt);
        check({tag, ":wr_strobes"}, wcnt, (exp_wcyc != 0) ? 1 : 0);
        check({tag, ":wr_cycle"}, wcyc, exp_wcyc);
        check({tag, ":rw_overlap"}, both, 0);
        if (exp_wcyc != 0) begin
            check({tag, ":wr_data"}, wdat, ref_word(a));
            check({tag, ":wr_addr"}, waddr, {addr[31:2], 2'b00});
        end
        check({tag, ":mem_word"}, dut_word(a), ref_word(a));
    endtask

    initial begin
        int bad;
        logic we;
        logic [2:0] f3;
        logic [31:0] addr;
        int sz;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst:req_ready", {31'd0, req_ready}, 32'd1);
        check("rst:resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst:resp_rdata", resp_rdata, 32'd0);
        check("rst:resp_err", {31'd0, resp_err}, 32'd0);
        check("rst:mem_strobes", {30'd0, mem_r_enb, mem_w_enb}, 32'd0);
        check("rst:mem_addr", mem_addr, 32'd0);
        check("rst:mem_w_data", mem_w_data, 32'd0);
        rst = 1'b1;

        run_req("sw10", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        run_req("lw10", 1'b0, 3'd2, 32'h10, 32'd0);
        run_req("sw20", 1'b1, 3'd2, 32'h20, 32'h11223344);
        run_req("lb23", 1'b0, 3'd0, 32'h23, 32'd0);
        run_req("sb20", 1'b1, 3'd0, 32'h20, 32'h00000080);
        run_req("lb20", 1'b0, 3'd0, 32'h20, 32'd0);
        run_req("lbu20", 1'b0, 3'd4, 32'h20, 32'd0);
        run_req("lh22", 1'b0, 3'd1, 32'h22, 32'd0);
        run_req("sw20b", 1'b1, 3'd2, 32'h20, 32'h11223344);
        run_req("sb21", 1'b1, 3'd0, 32'h21, 32'h000000AA);
        run_req("sh22", 1'b1, 3'd1, 32'h22, 32'h0000BEEF);
        run_req("lw20", 1'b0, 3'd2, 32'h20, 32'd0);
        run_req("lhu22", 1'b0, 3'd5, 32'h22, 32'd0);
        run_req("err_lw12", 1'b0, 3'd2, 32'h12, 32'd0);
        run_req("err_sh13", 1'b1, 3'd1, 32'h13, 32'h5555);
        run_req("err_f3_3", 1'b0, 3'd3, 32'h20, 32'd0);
        run_req("err_lw400", 1'b0, 3'd2, 32'h400, 32'd0);
        run_req("err_sbu", 1'b1, 3'd4, 32'h20, 32'hFF);

        // Reset while the read half of a byte store is in progress
        run_req("sw20c", 1'b1, 3'd2, 32'h20, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h21; req_wdata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid:rmw_read", {31'd0, mem_r_enb}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstmid:idle", {31'd0, req_ready}, 32'd1);
        bad = 0;
        for (int n = 0; n < 3; n++) begin
            if (resp_valid || mem_w_enb) bad++;
            @(negedge clk);
        end
        check("rstmid:quiet", bad, 0);
        run_req("rstmid:lw20", 1'b0, 3'd2, 32'h20, 32'd0);

        // Back-to-back: load presented while the store completes
        ref_mem[48] = 8'h0D; ref_mem[49] = 8'hF0; ref_mem[50] = 8'hFE; ref_mem[51] = 8'hCA;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        check("b2b:w_enb", {31'd0, mem_w_enb}, 32'd1);
        check("b2b:w_data", mem_w_data, 32'hCAFEF00D);
        req_we = 1'b0; req_wdata = 32'h12345678;
        @(negedge clk);
        check("b2b:sw_resp", {30'd0, resp_valid, req_ready}, 32'd3);
        check("b2b:sw_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b:pulse_once", {31'd0, resp_valid}, 32'd0);
        check("b2b:lw_read", {31'd0, mem_r_enb}, 32'd1);
        @(negedge clk);
        check("b2b:lw_resp", {31'd0, resp_valid}, 32'd1);
        check("b2b:lw_rdata", resp_rdata, ref_word(48));

        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 63));
            sz   = ref_size(f3);
            if (sz != 0 && $urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
            if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(10, 31));
            run_req($sformatf("rnd%0d", i), we, f3, addr, $urandom);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the RV32 core's execute stage and the byte-array data memory. It accepts one load or store request at a time, checks alignment and range, and issues word-granular accesses to the memory. Memory read is combinational; memory write is a full 32-bit word on the clock edge. Sub-word stores are therefore done as read-modify-write. Loads return byte/half/word data, sign- or zero-extended per RISC-V funct3.

Parameters:
ADDR_BITS, 10, byte-address width of data memory; request addresses with any bit set in addr[31:ADDR_BITS] are out of range.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-low reset (rst=0 at a rising edge resets)
req_valid  in  1  request present
req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores/errors
resp_err  out  1  qualifies resp_valid: misaligned, illegal funct3, or out of range
mem_addr  out  32  {addr_q[31:2],2'b00} while accessing, else 0
mem_r_enb  out  1  memory read strobe
mem_w_enb  out  1  memory write strobe
mem_w_data  out  32  word to write; 0 when mem_w_enb=0
mem_r_data  in  32  combinational read data from memory

Behaviour:
- Reset: state=IDLE. resp_valid=0, resp_rdata=0, resp_err=0. Request/merge buffers are 0. All mem_* outputs are 0. Memory contents are not touched.
- Memory strobes are decoded from the state register only (Moore), so they carry no glitch path from req_*. mem_r_enb and mem_w_enb are never both high.
- States: IDLE, LOAD, RMW_READ, WRITE.
- IDLE, on accept at cycle T: latch addr, funct3, we, wdata.
  - If the error condition holds: stay in IDLE. At T+1, resp_valid=1 and resp_err=1. No memory strobe is issued.
  - Otherwise: load goes to LOAD; SW goes to WRITE; SB/SH go to RMW_READ.
- Error condition: illegal funct3 (load 3,6,7; store ≥3), OR halfword with addr[0]=1, OR word with addr[1:0]≠0, OR addr[31:ADDR_BITS]≠0.
- LOAD (T+1):
  - mem_r_enb=1.
  - Extract byte k = mem_r_data[8k+7:8k] with k=addr[1:0] (little-endian), or half = addr[1] ? [31:16] : [15:0].
  - Sign-extend for funct3 0/1, zero-extend for 4/5.
  - Register the result into resp_rdata. At T+2, resp_valid=1 and state=IDLE.
- WRITE:
  - mem_w_enb=1 and mem_w_data=merge buffer (SW: wdata directly). The memory captures the word at the end of this cycle.
  - Next cycle: resp_valid=1, resp_rdata=0, state=IDLE.
  - Latency: SW response at T+2; SB/SH response at T+3.
- RMW_READ (T+1):
  - mem_r_enb=1.
  - Merge buffer = mem_r_data with the selected lane replaced. SB replaces byte addr[1:0] with wdata[7:0]. SH replaces half addr[1] with wdata[15:0].
  - Next state is WRITE.
- resp_valid is high for exactly one cycle per accepted request.
- A new request may be accepted in the same cycle resp_valid is high, since the block is back in IDLE.
- req_* inputs are ignored when not in IDLE. The latched copy is used throughout the operation.
- Reset mid-operation (any non-IDLE state): return to IDLE at that edge. No write strobe is issued afterwards and no resp_valid is produced.
  - Reset during RMW_READ means no memory change.
  - Reset during WRITE: the write is still performed only if the WRITE cycle completes before reset is sampled. The strobe is already high in that cycle, so the memory sees it.
- Back-to-back accesses to the same word must observe the prior write. No forwarding is needed because the write completes before the next read state.

Decomposition:
- Shared package/include lsu_defs holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encodings (2 bits)
  - the error-condition macro/function
- One combinational sub-module, lsu_align, contains:
  - the load extract/extend path (mem_r_data, addr[1:0], funct3 → rdata)
  - the store merge path (mem_r_data, wdata, addr[1:0], funct3 → merged word)
- The FSM, buffers and handshake stay in load_store_unit.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 → mem_w_enb at T+1 with data 0xDEADBEEF; resp_valid at T+2, resp_err=0; the load returns resp_rdata=0xDEADBEEF at T+2.
- After SW 0x11223344 @0x20: LB @0x23 → 0x00000011; LB @0x20 after SB 0x80 @0x20 → 0xFFFFFF80; LBU → 0x00000080; LH @0x22 → 0x00001122.
- SB 0xAA @0x21 over word 0x11223344 → RMW: read at T+1, write 0x1122AA44 at T+2, resp_valid at T+3. SH 0xBEEF @0x22 → 0xBEEFAA44.
- LW @0x12, SH @0x13, funct3=3 load, LW @0x400 (ADDR_BITS=10) → resp_valid and resp_err=1 at T+1, resp_rdata=0, no mem strobe, memory unchanged.
- rst=0 during RMW_READ of SB @0x21 → next cycle IDLE, no mem_w_enb, no resp_valid; subsequent LW @0x20 returns the unmodified word.
- Back-to-back: hold req_valid with SW then LW to the same address, accepted in consecutive IDLE cycles → second request accepted in the cycle of the first resp_valid; returns the newly written data.
